gray2bin_tracker: RTL and testbench
===================================

// Module: gray2bin_tracker
// PURPOSE
//   Receive side of the Gray-coded position interface: takes an asynchronous Gray-coded
//   bus (switches, rotary encoder or Gray counter from another domain), synchronises it,
//   decodes it to binary and checks that each change is a single-step move.
//   Accumulates a signed position count and flags illegal jumps.
//   Sits between board pins / CDC boundary and the LED/display logic.
// PARAMETERS
//   WIDTH        4   Gray/binary code width (>=2)
//   SYNC_STAGES  2   synchroniser flops on gray_in (>=2)
//   POS_W        16  width of signed position accumulator
// PORTS
//   clk       in   1            system clock
//   rst_n     in   1            synchronous reset, active low
//   gray_in   in   WIDTH        Gray-coded input, asynchronous to clk
//   clr       in   1            clear position/fault, re-prime tracker (sync, level)
//   bin_out   out  WIDTH        decoded binary value of last accepted sample
//   bin_valid out  1            1-cycle pulse when bin_out changes
//   step_up   out  1            1-cycle pulse: bin advanced by +1 (mod 2^WIDTH)
//   step_dn   out  1            1-cycle pulse: bin moved by -1 (mod 2^WIDTH)
//   wrap      out  1            1-cycle pulse with step on max->0 or 0->max
//   position  out  POS_W        signed step count since reset/clr, two's-complement wrap
//   ready     out  1            1 = tracker primed (state TRACK or FAULT)
//   err       out  1            sticky: illegal multi-step change detected
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): sync flops, all outputs, prime counter = 0; state INIT.
//   - Sync chain: SYNC_STAGES flops; decode bin[W-1]=g[W-1], bin[i]=bin[i+1]^g[i]
//     on the last sync stage, registered once (decode register).
//   - Latency: gray_in change stable before edge 0 -> bin_out/bin_valid/step at edge
//     SYNC_STAGES+1 (3 edges with default).
//   - delta = dec - bin_out (mod 2^WIDTH): 0 none; 1 up; 2^WIDTH-1 down; else illegal.
//   FSM:
//   - INIT: ready=0, no pulses. Prime counter counts SYNC_STAGES+1 cycles; on terminal
//     count load bin_out<=dec, position<=0, no bin_valid, -> TRACK.
//   - TRACK: up -> bin_out<=dec, bin_valid, step_up, position+1; down -> same with
//     step_dn, position-1; wrap with step when bin_out=max&dec=0 (up) or 0->max (down).
//     Illegal -> bin_out<=dec, bin_valid=1, no step, position unchanged, err<=1, -> FAULT.
//   - FAULT: bin_out/bin_valid keep following dec; step_up/step_dn/wrap held 0;
//     position frozen; err stays 1.
//   - clr (any state): next edge err<=0, position<=0, pulses 0, prime counter<=0,
//     -> INIT; clr wins over a simultaneous step/illegal event (event dropped).
//     clr held high keeps block in INIT.
//   - position wraps silently (0x7FFF+1 -> 0x8000, 0x0000-1 -> 0xFFFF for POS_W=16).
//   - step_up, step_dn mutually exclusive; pulses never exceed 1 cycle.
//   - rst_n low mid-operation: next edge all outputs 0, INIT, regardless of clr.
// TESTING (WIDTH=4, SYNC_STAGES=2, POS_W=16)
//   1 Reset, hold gray_in=4'b0110 -> ready=1 after 3 cycles, bin_out=4, position=0,
//     no bin_valid/step pulses.
//   2 From bin 4: gray 0111 then 0101, 10 cycles apart -> bin_out 5 then 6, two
//     step_up pulses each 3 edges after change, position=2, err=0.
//   3 Prime on gray 0000, then gray 1000 -> bin_out=15, step_dn+wrap same cycle,
//     position=16'hFFFF; back to 0000 -> step_up+wrap, position=0.
//   4 Prime on 0000, jump to 0011 (bin 2) -> err=1, bin_valid, no step; then 0010
//     (bin 3) -> bin_out=3, no step, position=0; clr 1 cycle -> err=0, ready=0, re-primes
//     to bin 3 after 3 cycles.
//   5 clr asserted the cycle a legal step reaches decode -> no step_up, position=0, INIT.
//   6 After 5 up-steps, rst_n low 1 cycle -> all outputs 0 next edge; re-primes on
//     current gray_in with position=0.

Source files
------------

// File: rtl/gray2bin_tracker.sv
// Gray-code position tracker: synchronises an asynchronous Gray bus, decodes it to binary,
// classifies each change as +1 / -1 / illegal and accumulates a signed step count.
module gray2bin_tracker #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int POS_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             wrap,
  output logic [POS_W-1:0] position,
  output logic             ready,
  output logic             err
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(SYNC_STAGES);
  localparam logic [WIDTH-1:0] BIN_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] BIN_MAX    = '1;
  localparam logic [WIDTH-1:0] BIN_ZERO   = '0;
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] dec_d, dec_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] prime_q, prime_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             wrap_q, wrap_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] delta;
  logic             is_move, is_up, is_dn;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking
  // assignments here would collapse the synchroniser chain into a single stage.
  // NOTE: the synchroniser flops are reset as well, so a reset clears every stage to 0
  // instead of leaving stale samples that priming would then load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      dec_q <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      dec_q <= dec_d;
    end
  end

  assign dec_d = gray_to_bin(sync_q[SYNC_STAGES-1]);

  assign delta   = dec_q - bin_q;
  assign is_move = (delta != BIN_ZERO);
  assign is_up   = (delta == BIN_ONE);
  assign is_dn   = (delta == BIN_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      prime_q <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      wrap_q  <= 1'b0;
      pos_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      wrap_q  <= wrap_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    wrap_d  = 1'b0;
    pos_d   = pos_q;
    err_d   = err_q;

    if (clr) begin
      state_d = S_INIT;
      prime_d = '0;
      pos_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          if (prime_q == PRIME_LAST) begin
            // Load from the decoder input: it already reflects the settled last sync
            // stage, and dec_q takes the same value on this edge.
            bin_d   = dec_d;
            pos_d   = '0;
            state_d = S_TRACK;
          end else begin
            prime_d = prime_q + CNT_W'(1);
          end
        end

        S_TRACK: begin
          if (is_move) begin
            bin_d   = dec_q;
            valid_d = 1'b1;
            if (is_up) begin
              up_d   = 1'b1;
              wrap_d = (bin_q == BIN_MAX);
              pos_d  = pos_q + POS_ONE;
            end else if (is_dn) begin
              dn_d   = 1'b1;
              wrap_d = (bin_q == BIN_ZERO);
              pos_d  = pos_q - POS_ONE;
            end else begin
              err_d   = 1'b1;
              state_d = S_FAULT;
            end
          end
        end

        S_FAULT: begin
          if (is_move) begin
            bin_d   = dec_q;
            valid_d = 1'b1;
          end
        end

        default: begin
          state_d = S_INIT;
          prime_d = '0;
        end
      endcase
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = valid_q;
  assign step_up   = up_q;
  assign step_dn   = dn_q;
  assign wrap      = wrap_q;
  assign position  = pos_q;
  assign ready     = (state_q != S_INIT);
  assign err       = err_q;

endmodule

// File: tb/tb_gray2bin_tracker.sv
// Directed bench for gray2bin_tracker: every bin_valid event is matched against a
// scoreboard entry queued when the corresponding Gray change was driven.
module tb_gray2bin_tracker;

  logic        clk;
  logic        rst_n;
  logic [3:0]  gray_in;
  logic        clr;
  logic [3:0]  bin_out;
  logic        bin_valid;
  logic        step_up;
  logic        step_dn;
  logic        wrap;
  logic [15:0] position;
  logic        ready;
  logic        err;

  typedef struct packed {
    logic [3:0]  bin;
    logic        up;
    logic        dn;
    logic        wr;
    logic [15:0] pos;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  gray2bin_tracker #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .POS_W      (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gray_in  (gray_in),
    .clr      (clr),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .step_up  (step_up),
    .step_dn  (step_dn),
    .wrap     (wrap),
    .position (position),
    .ready    (ready),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] b, input logic u, input logic d, input logic w,
                      input logic [15:0] p);
    exp_t e;
    e.bin = b;
    e.up  = u;
    e.dn  = d;
    e.wr  = w;
    e.pos = p;
    sb_q.push_back(e);
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Scoreboard side: compare each output event away from the active edge.
  always @(negedge clk) begin
    if (rst_n && bin_valid) begin
      check("sb_underflow", {31'd0, sb_q.size() == 0}, 32'd0);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_event", {9'd0, bin_out, step_up, step_dn, wrap, position}, {9'd0, e});
      end
    end
    if (step_up || step_dn || wrap) begin
      check("pulse_needs_valid", {31'd0, bin_valid}, 32'd1);
      check("up_dn_exclusive", {31'd0, step_up & step_dn}, 32'd0);
    end
  end

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    gray_in = 4'b0110;

    // 1: reset state, then prime on gray 0110 (bin 4)
    tick(1);
    check("rst_bin_out", {28'd0, bin_out}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_position", {16'd0, position}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("prime_not_yet", {31'd0, ready}, 32'd0);
    tick(1);
    check("prime_ready", {31'd0, ready}, 32'd1);
    check("prime_bin", {28'd0, bin_out}, 32'd4);
    check("prime_pos", {16'd0, position}, 32'd0);
    check("prime_no_valid", {31'd0, bin_valid}, 32'd0);

    // 2: two up-steps, latency of three edges after the first sampling edge
    gray_in = 4'b0111;
    push(4'd5, 1'b1, 1'b0, 1'b0, 16'd1);
    tick(3);
    check("lat_early", {31'd0, bin_valid}, 32'd0);
    tick(1);
    check("lat_valid", {31'd0, bin_valid}, 32'd1);
    check("lat_step_up", {31'd0, step_up}, 32'd1);
    tick(6);
    gray_in = 4'b0101;
    push(4'd6, 1'b1, 1'b0, 1'b0, 16'd2);
    tick(4);
    check("up2_pos", {16'd0, position}, 32'd2);
    check("up2_err", {31'd0, err}, 32'd0);
    tick(1);
    check("pulse_one_cycle", {31'd0, bin_valid | step_up}, 32'd0);

    // 3: re-prime on 0000, wrap down to 15 and back up to 0
    gray_in = 4'b0000;
    clr     = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_ready", {31'd0, ready}, 32'd0);
    check("clr_pos", {16'd0, position}, 32'd0);
    tick(3);
    check("reprime0_ready", {31'd0, ready}, 32'd1);
    check("reprime0_bin", {28'd0, bin_out}, 32'd0);
    gray_in = 4'b1000;
    push(4'd15, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    tick(4);
    check("wrap_dn", {29'd0, step_dn, wrap, step_up}, 32'b110);
    check("wrap_dn_pos", {16'd0, position}, 32'h0000_FFFF);
    tick(6);
    gray_in = 4'b0000;
    push(4'd0, 1'b1, 1'b0, 1'b1, 16'd0);
    tick(4);
    check("wrap_up", {29'd0, step_dn, wrap, step_up}, 32'b011);
    check("wrap_up_pos", {16'd0, position}, 32'd0);

    // 4: illegal jump 0 -> 2, fault keeps following, clr re-primes
    tick(6);
    gray_in = 4'b0011;
    push(4'd2, 1'b0, 1'b0, 1'b0, 16'd0);
    tick(4);
    check("illegal_err", {31'd0, err}, 32'd1);
    check("illegal_valid", {31'd0, bin_valid}, 32'd1);
    check("illegal_no_step", {31'd0, step_up | step_dn}, 32'd0);
    tick(6);
    gray_in = 4'b0010;
    push(4'd3, 1'b0, 1'b0, 1'b0, 16'd0);
    tick(4);
    check("fault_bin", {28'd0, bin_out}, 32'd3);
    check("fault_err_sticky", {31'd0, err}, 32'd1);
    check("fault_ready", {31'd0, ready}, 32'd1);
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("fault_clr_err", {31'd0, err}, 32'd0);
    check("fault_clr_ready", {31'd0, ready}, 32'd0);
    tick(3);
    check("fault_reprime_ready", {31'd0, ready}, 32'd1);
    check("fault_reprime_bin", {28'd0, bin_out}, 32'd3);

    // 5: clr wins over a legal step arriving at the decode register
    gray_in = 4'b0110;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_drop_step", {30'd0, bin_valid, step_up}, 32'd0);
    check("clr_drop_ready", {31'd0, ready}, 32'd0);
    check("clr_drop_pos", {16'd0, position}, 32'd0);
    tick(3);
    check("clr_drop_reprime", {28'd0, bin_out}, 32'd4);

    // 6: five up-steps, then reset mid-operation
    for (int k = 1; k <= 5; k++) begin
      gray_in = to_gray(4'(4 + k));
      push(4'(4 + k), 1'b1, 1'b0, 1'b0, 16'(k));
      tick(5);
    end
    check("five_up_pos", {16'd0, position}, 32'd5);
    rst_n = 1'b0;
    tick(1);
    check("midrst_outputs", {8'd0, bin_out, bin_valid, step_up, step_dn, wrap, ready, err,
                             position}, 32'd0);
    rst_n = 1'b1;
    tick(3);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_bin", {28'd0, bin_out}, 32'd9);
    check("midrst_pos", {16'd0, position}, 32'd0);

    tick(2);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
